glyph_column_decoder: RTL and testbench
=======================================

// Module: glyph_column_decoder
// PURPOSE
// - Receive end of the 5-row dot-matrix column stream: one 5-bit column per beat,
//   bit4 = top row; 5'h00 is the inter-glyph blank column.
// - Collects the columns of one glyph, matches them against a fixed glyph table,
//   and emits the 8-bit ASCII code on a valid/ready output.
// - Sits between the column-pattern source and any character sink (UART tx, log FIFO).
// PARAMETERS
// - MAX_COLS  5  column buffer depth; a glyph longer than this is unknown (range 4..8)
// - UNK_CHAR  8'h3F  ASCII code emitted for an unmatched glyph ('?')
// PORTS
// - clk         in   1  single clock, all logic on rising edge
// - rst         in   1  synchronous, active-high reset
// - col_valid   in   1  col_data is valid this cycle
// - col_data    in   5  column pattern
// - col_ready   out  1  decoder accepts col_data; a beat transfers when col_valid & col_ready
// - char_valid  out  1  char_data holds a decoded character
// - char_data   out  8  ASCII code
// - char_ready  in   1  sink accepts; a char transfers when char_valid & char_ready
// - char_err    out  1  qualifies char_data: 1 = glyph unmatched or overflowed
// BEHAVIOUR
// - Reset values: col_ready=0 during rst, then 1; char_valid=0; char_data=8'h00; char_err=0.
// - Reset also clears state, column count and buffer, whatever the current state.
// - Glyph table, exact column sequence and exact column count:
//   'p'(8'h70) = 1f,14,14,1c
//   'r'(8'h72) = 1f,14,16,1d
//   'a'(8'h61) = 1f,14,14,1f
//   's'(8'h73) = 1d,15,15,17
//   'n'(8'h6E) = 1f,08,04,02,1f
// - FSM states: IDLE, COLLECT, EMIT.
//   - IDLE: an accepted 5'h00 is discarded (leading/repeated blanks). An accepted non-zero
//     column is stored at buffer[0], cnt=1, and the FSM goes to COLLECT.
//   - COLLECT: an accepted non-zero column is stored at buffer[cnt] and cnt increments.
//     If cnt is already MAX_COLS, ovf is set and the column is dropped (cnt holds).
//   - COLLECT, accepted 5'h00: compare buffer[0..cnt-1] and cnt against the table
//     (combinational). Register char_data = match ? code : UNK_CHAR and
//     char_err = ~match | ovf. Go to EMIT. ovf forces no-match.
//   - EMIT: char_valid=1 and col_ready=0. Hold char_data/char_err stable until
//     char_ready=1. On transfer: char_valid=0, cnt=0, ovf=0, go to IDLE.
// - Latency: char_valid rises the cycle after the terminating 5'h00 is accepted.
// - Throughput: one glyph per (ncols + 1 separator + 1 EMIT) cycles when char_ready=1.
// - char_ready=1 while char_valid=0 is ignored. col_valid while col_ready=0 is not
//   consumed; the source must hold the beat.
// - No glyph is emitted without a terminating 5'h00; a trailing partial glyph waits.
// - col_data is don't-care when col_valid=0.
// CONFIGURATION
// - GLYPH_STATS_EN defined: adds ports glyph_cnt [15:0] and unk_cnt [15:0].
//   - Both counters are out, reset to 0, saturate at 16'hFFFF.
//   - glyph_cnt increments on each char transfer; unk_cnt increments on each char
//     transfer with char_err=1.
// - GLYPH_STATS_EN undefined: the ports and counters do not exist; all other
//   behaviour is identical.
// TESTING
// - Stream 1f,14,14,1c,00 with char_ready=1 -> one char: char_data=8'h70, char_err=0,
//   char_valid 1 cycle after the 00.
// - Full stream p,r,a,s,a,n,n,a (each glyph followed by 00) -> chars 70,72,61,73,61,6E,6E,61
//   in order, char_err=0 on all.
// - Leading 00,00 then 1f,14,14,1f,00 -> single 8'h61; no char for the blank columns.
// - 1f,14,14,1e,00 -> 8'h3F with char_err=1. Six non-zero columns then 00 (MAX_COLS=5)
//   -> 8'h3F with char_err=1. Then 1f,14,16,1d,00 -> 8'h72 with char_err=0.
// - Hold char_ready=0 for 10 cycles after a glyph:
//   - char_data stays stable and col_ready=0 throughout.
//   - On release, one transfer only, then col_ready=1 the next cycle.
// - Assert rst mid-glyph (after 1f,14) and in EMIT:
//   - Outputs return to reset values next cycle.
//   - Next 1f,08,04,02,1f,00 -> 8'h6E.
//   - With GLYPH_STATS_EN, glyph_cnt/unk_cnt read 0 after rst and count 3/1 after
//     sequence a, ?, n.

Source files
------------

// File: rtl/glyph_column_decoder_if.sv
// Column-stream input and character-stream output of the glyph column decoder.
// The master side feeds columns and sinks characters; the decoder is the slave.
interface glyph_column_decoder_if;
    logic       col_valid;
    logic [4:0] col_data;
    logic       col_ready;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       char_err;

    modport master (
        output col_valid, col_data, char_ready,
        input  col_ready, char_valid, char_data, char_err
    );

    modport slave (
        input  col_valid, col_data, char_ready,
        output col_ready, char_valid, char_data, char_err
    );
endinterface

// File: rtl/glyph_column_decoder.sv
// Collects 5-row dot-matrix columns up to a blank column and emits the matching ASCII code.
// Optional macro GLYPH_STATS_EN adds saturating glyph_cnt / unk_cnt statistics ports.
module glyph_column_decoder #(
    parameter int         MAX_COLS = 5,
    parameter logic [7:0] UNK_CHAR = 8'h3F
) (
    input  logic clk,
    input  logic rst,
`ifdef GLYPH_STATS_EN
    output logic [15:0] glyph_cnt,
    output logic [15:0] unk_cnt,
`endif
    glyph_column_decoder_if.slave bus
);
    localparam int CNT_W      = $clog2(MAX_COLS + 1);
    localparam int NUM_GLYPHS = 5;
    localparam int TBL_COLS   = 5;
    localparam int CMP_COLS   = (MAX_COLS < TBL_COLS) ? MAX_COLS : TBL_COLS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COLS);

    localparam logic [7:0] GLYPH_CODE [NUM_GLYPHS] = '{8'h70, 8'h72, 8'h61, 8'h73, 8'h6E};
    localparam int         GLYPH_LEN  [NUM_GLYPHS] = '{4, 4, 4, 4, 5};
    localparam logic [4:0] GLYPH_COLS [NUM_GLYPHS][TBL_COLS] = '{
        '{5'h1f, 5'h14, 5'h14, 5'h1c, 5'h00},
        '{5'h1f, 5'h14, 5'h16, 5'h1d, 5'h00},
        '{5'h1f, 5'h14, 5'h14, 5'h1f, 5'h00},
        '{5'h1d, 5'h15, 5'h15, 5'h17, 5'h00},
        '{5'h1f, 5'h08, 5'h04, 5'h02, 5'h1f}
    };

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       buf_q [MAX_COLS];
    logic [4:0]       buf_d [MAX_COLS];
    logic [7:0]       char_data_q, char_data_d;
    logic             char_err_q, char_err_d;

    logic             col_accept;
    logic             char_xfer;
    logic             glyph_hit;
    logic [7:0]       glyph_code;
    logic             cols_equal;

    assign bus.col_ready  = ~rst && (state_q != EMIT);
    assign bus.char_valid = (state_q == EMIT);
    assign bus.char_data  = char_data_q;
    assign bus.char_err   = char_err_q;

    assign col_accept = bus.col_valid && bus.col_ready;
    assign char_xfer  = (state_q == EMIT) && bus.char_ready;

    // A glyph matches only when both the column count and every stored column agree.
    always_comb begin
        glyph_hit  = 1'b0;
        glyph_code = UNK_CHAR;
        cols_equal = 1'b0;
        for (int g = 0; g < NUM_GLYPHS; g++) begin
            cols_equal = (int'(cnt_q) == GLYPH_LEN[g]);
            for (int j = 0; j < CMP_COLS; j++) begin
                if (j < GLYPH_LEN[g] && buf_q[j] != GLYPH_COLS[g][j]) begin
                    cols_equal = 1'b0;
                end
            end
            if (cols_equal) begin
                glyph_hit  = 1'b1;
                glyph_code = GLYPH_CODE[g];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        buf_d       = buf_q;
        char_data_d = char_data_q;
        char_err_d  = char_err_q;
        case (state_q)
            IDLE: begin
                if (col_accept && bus.col_data != 5'h00) begin
                    buf_d[0] = bus.col_data;
                    cnt_d    = CNT_W'(1);
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (col_accept) begin
                    if (bus.col_data == 5'h00) begin
                        char_data_d = (glyph_hit && !ovf_q) ? glyph_code : UNK_CHAR;
                        char_err_d  = !glyph_hit || ovf_q;
                        state_d     = EMIT;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        buf_d[cnt_q] = bus.col_data;
                        cnt_d        = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.char_ready) begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            char_data_q <= 8'h00;
            char_err_q  <= 1'b0;
            for (int i = 0; i < MAX_COLS; i++) begin
                buf_q[i] <= 5'h00;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            char_data_q <= char_data_d;
            char_err_q  <= char_err_d;
            buf_q       <= buf_d;
        end
    end

`ifdef GLYPH_STATS_EN
    // Both counters advance only on an actual character handshake and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            glyph_cnt <= 16'h0000;
            unk_cnt   <= 16'h0000;
        end else if (char_xfer) begin
            if (glyph_cnt != 16'hFFFF) begin
                glyph_cnt <= glyph_cnt + 16'h0001;
            end
            if (char_err_q && unk_cnt != 16'hFFFF) begin
                unk_cnt <= unk_cnt + 16'h0001;
            end
        end
    end
`else
    logic unused_xfer;
    assign unused_xfer = char_xfer;
`endif
endmodule

// File: tb/tb_glyph_column_decoder.sv
// Directed-vector bench for glyph_column_decoder with a glyph-level reference model.
// Build with GLYPH_STATS_EN defined to also exercise the statistics counters.
module tb_glyph_column_decoder;
    localparam int MAX_COLS = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    glyph_column_decoder_if bus ();

`ifdef GLYPH_STATS_EN
    logic [15:0] glyph_cnt;
    logic [15:0] unk_cnt;
`endif

    glyph_column_decoder #(
        .MAX_COLS (MAX_COLS),
        .UNK_CHAR (8'h3F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef GLYPH_STATS_EN
        .glyph_cnt (glyph_cnt),
        .unk_cnt   (unk_cnt),
`endif
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [4:0] model_glyph [$];
    logic [8:0] model_pend  [$];
    logic [8:0] char_log    [$];
    logic       hold_prev = 1'b0;
    logic [8:0] hold_val  = 9'h000;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference decode: glyph as a whole column list, returned as {err, ascii}.
    function automatic logic [8:0] modelDecode(input logic [4:0] g [$]);
        logic [39:0] key;
        key = '0;
        if (g.size() > MAX_COLS) return {1'b1, 8'h3F};
        foreach (g[i]) key = {key[34:0], g[i]};
        if (g.size() == 4) begin
            case (key[19:0])
                {5'h1f, 5'h14, 5'h14, 5'h1c}: return {1'b0, 8'h70};
                {5'h1f, 5'h14, 5'h16, 5'h1d}: return {1'b0, 8'h72};
                {5'h1f, 5'h14, 5'h14, 5'h1f}: return {1'b0, 8'h61};
                {5'h1d, 5'h15, 5'h15, 5'h17}: return {1'b0, 8'h73};
                default: return {1'b1, 8'h3F};
            endcase
        end
        if (g.size() == 5 && key[24:0] == {5'h1f, 5'h08, 5'h04, 5'h02, 5'h1f}) return {1'b0, 8'h6E};
        return {1'b1, 8'h3F};
    endfunction

    // Compare process: checks outputs against the model every non-reset cycle, then
    // advances the model with whatever handshakes happen at the coming rising edge.
    always @(negedge clk) begin
        if (rst) begin
            model_glyph.delete();
            model_pend.delete();
            hold_prev = 1'b0;
        end else begin
            checkOutput("valid_vs_model", 16'(bus.char_valid), 16'(model_pend.size() != 0));
            checkOutput("col_ready_vs_model", 16'(bus.col_ready), 16'(model_pend.size() == 0));
            if (hold_prev)
                checkOutput("hold_stable", 16'({bus.char_err, bus.char_data}), 16'(hold_val));
            if (bus.char_valid && model_pend.size() != 0)
                checkOutput("char_vs_model", 16'({bus.char_err, bus.char_data}), 16'(model_pend[0]));
            hold_prev = bus.char_valid && !bus.char_ready;
            hold_val  = {bus.char_err, bus.char_data};
            if (bus.char_valid && bus.char_ready) begin
                char_log.push_back({bus.char_err, bus.char_data});
                if (model_pend.size() != 0) void'(model_pend.pop_front());
            end
            if (bus.col_valid && bus.col_ready) begin
                if (bus.col_data != 5'h00) begin
                    model_glyph.push_back(bus.col_data);
                end else if (model_glyph.size() != 0) begin
                    model_pend.push_back(modelDecode(model_glyph));
                    model_glyph.delete();
                end
            end
        end
    end

    // Presents one column and holds it until accepted; returns 1 time unit after the edge.
    task automatic applyStimulus(input logic [4:0] c);
        bus.col_valid = 1'b1;
        bus.col_data  = c;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.col_ready) begin
                @(posedge clk);
                #1;
                bus.col_valid = 1'b0;
                bus.col_data  = 5'($urandom);
                return;
            end
        end
        checkOutput("col_accept_timeout", 16'(0), 16'(1));
        bus.col_valid = 1'b0;
    endtask

    task automatic sendCols(input logic [4:0] cols [$]);
        foreach (cols[i]) applyStimulus(cols[i]);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkLog(input string name, input logic [8:0] exp [$]);
        checkOutput({name, "_count"}, 16'(char_log.size()), 16'(exp.size()));
        for (int i = 0; i < exp.size() && i < char_log.size(); i++)
            checkOutput(name, 16'(char_log[i]), 16'(exp[i]));
        char_log.delete();
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_valid"}, 16'(bus.char_valid), 16'(0));
        checkOutput({name, "_data"}, 16'(bus.char_data), 16'h00);
        checkOutput({name, "_err"}, 16'(bus.char_err), 16'(0));
        checkOutput({name, "_col_ready"}, 16'(bus.col_ready), 16'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] q   [$];
        logic [8:0] exp [$];

        rst            = 1'b1;
        bus.col_valid  = 1'b0;
        bus.col_data   = 5'h00;
        bus.char_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        #1;
        checkOutput("col_ready_after_reset", 16'(bus.col_ready), 16'(1));

        $display("[TB] single glyph p");
        q = '{5'h1f, 5'h14, 5'h14, 5'h1c, 5'h00};
        sendCols(q);
        checkOutput("latency_valid", 16'(bus.char_valid), 16'(1));
        checkOutput("p_data", 16'(bus.char_data), 16'h70);
        checkOutput("p_err", 16'(bus.char_err), 16'(0));
        idleCycles(2);
        exp = '{9'h070};
        checkLog("p_log", exp);

        $display("[TB] word p r a s a n n a");
        q = '{5'h1f, 5'h14, 5'h14, 5'h1c, 5'h00, 5'h1f, 5'h14, 5'h16, 5'h1d, 5'h00,
              5'h1f, 5'h14, 5'h14, 5'h1f, 5'h00, 5'h1d, 5'h15, 5'h15, 5'h17, 5'h00,
              5'h1f, 5'h14, 5'h14, 5'h1f, 5'h00, 5'h1f, 5'h08, 5'h04, 5'h02, 5'h1f, 5'h00,
              5'h1f, 5'h08, 5'h04, 5'h02, 5'h1f, 5'h00, 5'h1f, 5'h14, 5'h14, 5'h1f, 5'h00};
        sendCols(q);
        idleCycles(2);
        exp = '{9'h070, 9'h072, 9'h061, 9'h073, 9'h061, 9'h06E, 9'h06E, 9'h061};
        checkLog("word_log", exp);

        $display("[TB] leading blanks");
        q = '{5'h00, 5'h00, 5'h1f, 5'h14, 5'h14, 5'h1f, 5'h00};
        sendCols(q);
        idleCycles(2);
        exp = '{9'h061};
        checkLog("blank_log", exp);

        $display("[TB] unknown, overflow, recovery");
        q = '{5'h1f, 5'h14, 5'h14, 5'h1e, 5'h00, 5'h1f, 5'h14, 5'h14, 5'h1c, 5'h1f, 5'h14, 5'h00,
              5'h1f, 5'h14, 5'h16, 5'h1d, 5'h00};
        sendCols(q);
        idleCycles(2);
        exp = '{9'h13F, 9'h13F, 9'h072};
        checkLog("unk_log", exp);

        $display("[TB] backpressure");
        bus.char_ready = 1'b0;
        q = '{5'h1d, 5'h15, 5'h15, 5'h17, 5'h00};
        sendCols(q);
        idleCycles(10);
        checkOutput("stall_data", 16'(bus.char_data), 16'h73);
        checkOutput("stall_col_ready", 16'(bus.col_ready), 16'(0));
        checkOutput("stall_no_xfer", 16'(char_log.size()), 16'(0));
        bus.char_ready = 1'b1;
        idleCycles(1);
        checkOutput("release_col_ready", 16'(bus.col_ready), 16'(1));
        checkOutput("release_valid", 16'(bus.char_valid), 16'(0));
        idleCycles(3);
        exp = '{9'h073};
        checkLog("stall_log", exp);

        $display("[TB] reset mid-glyph");
        q = '{5'h1f, 5'h14};
        sendCols(q);
        rst = 1'b1;
        idleCycles(1);
        checkResetOutputs("rst_mid");
        rst = 1'b0;
        q = '{5'h1f, 5'h08, 5'h04, 5'h02, 5'h1f, 5'h00};
        sendCols(q);
        idleCycles(2);
        exp = '{9'h06E};
        checkLog("rst_mid_log", exp);

        $display("[TB] reset in EMIT");
        bus.char_ready = 1'b0;
        q = '{5'h1f, 5'h14, 5'h14, 5'h1f, 5'h00};
        sendCols(q);
        checkOutput("emit_valid", 16'(bus.char_valid), 16'(1));
        rst = 1'b1;
        idleCycles(1);
        checkResetOutputs("rst_emit");
        rst = 1'b0;
        bus.char_ready = 1'b1;
`ifdef GLYPH_STATS_EN
        checkOutput("glyph_cnt_rst", glyph_cnt, 16'd0);
        checkOutput("unk_cnt_rst", unk_cnt, 16'd0);
`endif
        q = '{5'h1f, 5'h14, 5'h14, 5'h1f, 5'h00, 5'h1f, 5'h14, 5'h14, 5'h1e, 5'h00,
              5'h1f, 5'h08, 5'h04, 5'h02, 5'h1f, 5'h00};
        sendCols(q);
        idleCycles(2);
        exp = '{9'h061, 9'h13F, 9'h06E};
        checkLog("post_rst_log", exp);
`ifdef GLYPH_STATS_EN
        checkOutput("glyph_cnt", glyph_cnt, 16'd3);
        checkOutput("unk_cnt", unk_cnt, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
